traffic_light_monitor: RTL and testbench

Independent checker at the receiving end of the lamp-drive interface: observes the `street_a`/`street_b` lamp codes produced by the traffic-light FSM and verifies encoding, mutual exclusion, phase order and phase dwell times. Dwell is measured in 1 Hz tick pulses. Any violation latches a sticky fault with a cause code until software/operator acknowledge. The block sits alongside the controller top, fed by the same clock, the lamp outputs and the divider's 1 Hz tick.

---
 rtl/traffic_light_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Independent checker for the lamp-drive interface of a two-street traffic
// light controller. It watches the lamp codes and verifies:
//   - each lamp code is one-hot,
//   - the two streets never show a non-red aspect at the same time,
//   - phases follow AG/BR -> AY/BR -> AR/BG -> AR/BY -> AG/BR,
//   - each phase dwells for the expected number of 1 Hz ticks (+/- TOL).
// The first violation latches a sticky fault with a cause code until ack.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tick         1 Hz enable pulse, one clk wide
//   street_a     lamp code street A, {red, yellow, green}
//   street_b     lamp code street B, same encoding
//   ack          fault acknowledge pulse
//   fault        sticky fault flag
//   fault_code   0 none, 1 CONFLICT, 2 ILLEGAL, 3 SEQUENCE, 4 TIMING, 5 STUCK
//   phase        tracked phase, 0 AG/BR, 1 AY/BR, 2 AR/BG, 3 AR/BY
//   phase_time   ticks elapsed in the current phase (saturating)
//   cycle_count  completed full cycles (wraps)
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int G_TIME = 5,
    parameter int Y_TIME = 2,
    parameter int TOL    = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [2:0]       street_a,
    input  logic [2:0]       street_b,
    input  logic             ack,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] phase_time,
    output logic [15:0]      cycle_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_NONE     = 3'd0,
        C_CONFLICT = 3'd1,
        C_ILLEGAL  = 3'd2,
        C_SEQUENCE = 3'd3,
        C_TIMING   = 3'd4,
        C_STUCK    = 3'd5
    } code_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] G_MIN = CNT_W'(G_TIME - TOL);
    localparam logic [CNT_W-1:0] G_MAX = CNT_W'(G_TIME + TOL);
    localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(Y_TIME - TOL);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(Y_TIME + TOL);
    localparam logic [CNT_W-1:0] T_SAT = '1;

    state_t     state;
    logic [2:0] cur_a, cur_b;
    logic [2:0] prev_a, prev_b;
    // cur/prev reset to 000, which is itself an illegal code; cur_valid keeps
    // the checks quiet until cur holds a real sample of the lamps.
    logic       cur_valid;
    // Set while tracking the first phase after INIT: its start time is
    // unknown, so only the upper dwell bound applies to it.
    logic       first_phase;

    function automatic logic lamp_legal(input logic [2:0] c);
        return (c == RED) || (c == YEL) || (c == GRN);
    endfunction

    logic             a_legal, b_legal;
    logic             cur_is_phase;
    logic [1:0]       cur_phase;
    logic [1:0]       next_phase;
    logic             pair_change;
    logic [CNT_W-1:0] win_min, win_max;
    code_t            viol;

    assign a_legal     = lamp_legal(cur_a);
    assign b_legal     = lamp_legal(cur_b);
    assign next_phase  = phase + 2'd1;
    assign pair_change = {cur_a, cur_b} != {prev_a, prev_b};
    // Odd phases are the yellow ones.
    assign win_min     = phase[0] ? Y_MIN : G_MIN;
    assign win_max     = phase[0] ? Y_MAX : G_MAX;

    // NOTE: every signal written in an always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        cur_is_phase = 1'b1;
        cur_phase    = 2'd0;
        case ({cur_a, cur_b})
            {GRN, RED}: cur_phase = 2'd0;
            {YEL, RED}: cur_phase = 2'd1;
            {RED, GRN}: cur_phase = 2'd2;
            {RED, YEL}: cur_phase = 2'd3;
            default:    cur_is_phase = 1'b0;
        endcase
    end

    // Violation detection, in priority order. In FAULT only the code checks
    // run: they decide whether an ack may release the fault.
    always_comb begin
        viol = C_NONE;
        if (cur_valid) begin
            if (a_legal && b_legal && cur_a != RED && cur_b != RED)
                viol = C_CONFLICT;
            else if (!cur_is_phase)
                // Covers non-one-hot codes and legal pairs such as both red.
                viol = C_ILLEGAL;
        end
        if (viol == C_NONE && state == S_TRACK) begin
            if (pair_change) begin
                if (cur_phase != next_phase)
                    viol = C_SEQUENCE;
                else if (phase_time > win_max ||
                         (!first_phase && phase_time < win_min))
                    viol = C_TIMING;
            end else if (tick && phase_time >= win_max) begin
                viol = C_STUCK;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            cur_a       <= '0;
            cur_b       <= '0;
            prev_a      <= '0;
            prev_b      <= '0;
            cur_valid   <= 1'b0;
            first_phase <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= C_NONE;
            phase       <= 2'd0;
            phase_time  <= '0;
            cycle_count <= '0;
        end else begin
            cur_a     <= street_a;
            cur_b     <= street_b;
            prev_a    <= cur_a;
            prev_b    <= cur_b;
            cur_valid <= 1'b1;

            case (state)
                S_INIT: begin
                    if (viol != C_NONE) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= viol;
                    end else if (cur_valid) begin
                        // No violation on a valid sample means cur is a phase.
                        state       <= S_TRACK;
                        phase       <= cur_phase;
                        phase_time  <= '0;
                        first_phase <= 1'b1;
                    end
                end

                S_TRACK: begin
                    if (viol != C_NONE) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= viol;
                    end else if (pair_change) begin
                        // A tick on the change cycle is deliberately dropped.
                        phase       <= cur_phase;
                        phase_time  <= '0;
                        first_phase <= 1'b0;
                        if (phase == 2'd3)
                            cycle_count <= cycle_count + 16'd1;
                    end else if (tick && phase_time != T_SAT) begin
                        phase_time <= phase_time + 1'b1;
                    end
                end

                S_FAULT: begin
                    // A live violation outranks ack; the latched code stays.
                    if (ack && viol == C_NONE) begin
                        state      <= S_INIT;
                        fault      <= 1'b0;
                        fault_code <= C_NONE;
                        phase_time <= '0;
                    end
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. A behavioural model follows the
// checker rules using plain integers and a phase lookup table; a compare
// process checks every DUT output against it on each falling edge outside
// reset. Hand-computed literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    localparam int G_TIME = 5;
    localparam int Y_TIME = 2;
    localparam int TOL    = 1;
    localparam int CNT_W  = 8;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [2:0]       street_a, street_b;
    logic             ack;
    logic             fault;
    logic [2:0]       fault_code;
    logic [1:0]       phase;
    logic [CNT_W-1:0] phase_time;
    logic [15:0]      cycle_count;

    traffic_light_monitor #(
        .G_TIME(G_TIME), .Y_TIME(Y_TIME), .TOL(TOL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .street_a(street_a), .street_b(street_b), .ack(ack),
        .fault(fault), .fault_code(fault_code), .phase(phase),
        .phase_time(phase_time), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int         m_state;   // 0 waiting for a phase, 1 tracking, 2 faulted
    int         m_fault, m_code, m_phase, m_time, m_cycles;
    bit         m_first;
    logic [2:0] h_a, h_b;  // lamps captured one edge ago (being judged)
    logic [2:0] o_a, o_b;  // lamps captured two edges ago
    bit         have;
    int         mv, mp;

    function automatic int find_phase(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] ta [4];
        logic [2:0] tb [4];
        ta = '{G, Y, R, R};
        tb = '{R, R, G, Y};
        for (int i = 0; i < 4; i++)
            if (a == ta[i] && b == tb[i]) return i;
        return -1;
    endfunction

    function automatic int dwell(input int p);
        return (p % 2 == 1) ? Y_TIME : G_TIME;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_fault = 0; m_code = 0; m_phase = 0;
                m_time = 0; m_cycles = 0; m_first = 0;
                h_a = 0; h_b = 0; o_a = 0; o_b = 0; have = 0;
            end else begin
                mv = 0;
                mp = find_phase(h_a, h_b);
                if (have) begin
                    if ($countones(h_a) == 1 && $countones(h_b) == 1 &&
                        h_a != R && h_b != R)
                        mv = 1;
                    else if (mp < 0)
                        mv = 2;
                end
                case (m_state)
                    0: begin
                        if (mv != 0) begin
                            m_state = 2; m_fault = 1; m_code = mv;
                        end else if (have) begin
                            m_state = 1; m_phase = mp; m_time = 0; m_first = 1;
                        end
                    end
                    1: begin
                        if (mv == 0) begin
                            if ({h_a, h_b} != {o_a, o_b}) begin
                                if (mp != (m_phase + 1) % 4)
                                    mv = 3;
                                else if (m_time > dwell(m_phase) + TOL ||
                                         (!m_first && m_time < dwell(m_phase) - TOL))
                                    mv = 4;
                                else begin
                                    if (m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
                                    m_phase = mp; m_time = 0; m_first = 0;
                                end
                            end else if (tick) begin
                                if (m_time + 1 > dwell(m_phase) + TOL) mv = 5;
                                else if (m_time < 255) m_time = m_time + 1;
                            end
                        end
                        if (mv != 0) begin
                            m_state = 2; m_fault = 1; m_code = mv;
                        end
                    end
                    default: begin
                        if (ack && mv == 0) begin
                            m_state = 0; m_fault = 0; m_code = 0; m_time = 0;
                        end
                    end
                endcase
                o_a = h_a; o_b = h_b;
                h_a = street_a; h_b = street_b;
                have = 1;
            end
        end
    end

    // Compare process: outputs are checked on every falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("fault",       fault,       m_fault);
                check("fault_code",  fault_code,  m_code);
                check("phase",       phase,       m_phase);
                check("phase_time",  phase_time,  m_time);
                check("cycle_count", cycle_count, m_cycles);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(2);
        end
    endtask

    // Change the lamps; after this the change has been judged (two edges).
    task automatic set_lamps(input logic [2:0] a, input logic [2:0] b);
        street_a = a;
        street_b = b;
        cyc(2);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ack = 1'b0;
        street_a = G; street_b = R;
        cyc(2);
        check("rst_fault",  fault,       0);
        check("rst_code",   fault_code,  0);
        check("rst_phase",  phase,       0);
        check("rst_time",   phase_time,  0);
        check("rst_cycles", cycle_count, 0);
        rst = 1'b0;
        cyc(2);
        check("init_phase", phase, 0);

        // Nominal: three full cycles with exact dwell times.
        repeat (3) begin
            hold(5);
            set_lamps(Y, R); check("nom_ph1", phase, 1);
            hold(2);
            set_lamps(R, G); check("nom_ph2", phase, 2);
            hold(5);
            set_lamps(R, Y); check("nom_ph3", phase, 3);
            hold(2);
            set_lamps(G, R); check("nom_ph0", phase, 0);
        end
        check("nom_cycles", cycle_count, 3);
        check("nom_fault",  fault,       0);

        // Conflict: fault appears two edges after the input change.
        street_a = G; street_b = G;
        cyc(1); check("conf_lat_fault", fault, 0);
        cyc(1); check("conf_fault", fault, 1);
        check("conf_code", fault_code, 1);
        street_a = Y;
        cyc(3); check("conf_code_kept", fault_code, 1);
        // ack while the conflict is still present: fault stays.
        pulse_ack();
        check("ack_conf_fault", fault, 1);
        check("ack_conf_code",  fault_code, 1);

        // ack with legal lamps: back to INIT, then resume tracking.
        set_lamps(R, G);
        pulse_ack();
        check("ack_fault", fault,      0);
        check("ack_code",  fault_code, 0);
        check("ack_time",  phase_time, 0);
        cyc(1);
        check("resume_phase",  phase,       2);
        check("resume_cycles", cycle_count, 3);

        // Timing: leave a (non-first) green after 3 ticks.
        hold(2); set_lamps(R, Y);
        hold(2); set_lamps(G, R);
        check("tim_cycles", cycle_count, 4);
        hold(3); set_lamps(Y, R);
        check("tim_fault", fault, 1);
        check("tim_code",  fault_code, 4);
        check("tim_phase", phase, 0);
        check("tim_time",  phase_time, 3);

        // Timing upper edge: 6 ticks of green is still accepted.
        pulse_ack(); cyc(1);
        hold(2); set_lamps(R, G);
        hold(6);
        check("edge_time", phase_time, 6);
        set_lamps(R, Y);
        check("edge_fault", fault, 0);
        check("edge_phase", phase, 3);

        // Stuck: 4th tick in yellow.
        hold(2); set_lamps(G, R);
        hold(5); set_lamps(Y, R);
        hold(3);
        check("stuck_pre", fault, 0);
        hold(1);
        check("stuck_fault", fault, 1);
        check("stuck_code",  fault_code, 5);
        check("stuck_time",  phase_time, 3);

        // Sequence: jump from phase 0 to phase 2.
        set_lamps(G, R);
        pulse_ack(); cyc(1);
        set_lamps(R, G);
        check("seq_code", fault_code, 3);

        // ack on the very edge a conflict is detected in TRACK.
        set_lamps(G, R);
        pulse_ack(); cyc(1);
        street_a = G; street_b = G;
        cyc(1);
        pulse_ack();
        check("ack_same_fault", fault, 1);
        check("ack_same_code",  fault_code, 1);

        // Asynchronous reset mid-phase.
        set_lamps(G, R);
        pulse_ack(); cyc(1);
        hold(2);
        check("pre_rst_time",   phase_time,  2);
        check("pre_rst_cycles", cycle_count, 5);
        #3 rst = 1'b1;
        #1;
        check("arst_fault",  fault,       0);
        check("arst_code",   fault_code,  0);
        check("arst_phase",  phase,       0);
        check("arst_time",   phase_time,  0);
        check("arst_cycles", cycle_count, 0);
        cyc(1);

        // Illegal code on street A.
        street_a = 3'b011; street_b = R;
        rst = 1'b0;
        cyc(1); check("ill_lat", fault, 0);
        cyc(1);
        check("ill_fault", fault, 1);
        check("ill_code",  fault_code, 2);

        // Both red is a legal pair but not a phase.
        rst = 1'b1; cyc(1);
        street_a = R; street_b = R;
        rst = 1'b0;
        cyc(2);
        check("red_red_code", fault_code, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
